// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall controller bundle.
// Pipeline side (master) drives register indices, hazard qualifiers and the
// data-memory handshake; the controller (slave) returns forwarding selects,
// per-stage stall/flush pins, the sticky timeout flag and the stall counter.
//   rs1_d/rs2_d          source regs in ID
//   rs1_e/rs2_e/rd_e     source/dest regs in EX, load_e, pc_src_e
//   rd_m/reg_write_m     MEM writeback target
//   rd_w/reg_write_w     WB writeback target
//   dmem_req_m/dmem_ack  data-memory handshake
//   forward_a_e/b_e      00 regfile, 01 WB result, 10 MEM ALU result
//   stall_f/d/e/m        hold PC / IF-ID / ID-EX / EX-MEM
//   flush_d/e/w          clear IF-ID / ID-EX / MEM-WB
//   mem_err, stall_cycles
interface hazard_stall_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] rs1_d, rs2_d;
    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
    logic              load_e;
    logic              pc_src_e;
    logic [REG_AW-1:0] rd_m;
    logic              reg_write_m;
    logic [REG_AW-1:0] rd_w;
    logic              reg_write_w;
    logic              dmem_req_m;
    logic              dmem_ack;
    logic [1:0]        forward_a_e, forward_b_e;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, flush_w;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, pc_src_e,
               rd_m, reg_write_m, rd_w, reg_write_w, dmem_req_m, dmem_ack,
        input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, mem_err, stall_cycles
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, pc_src_e,
               rd_m, reg_write_m, rd_w, reg_write_w, dmem_req_m, dmem_ack,
        output forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, mem_err, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage RV32I pipeline.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   hz     hazard_stall_ctrl_if.slave (pipeline hazard inputs, stall/flush
//          outputs, forwarding selects, mem_err, stall_cycles)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no outstanding data-memory wait
// WAIT  | MEM stage waiting for dmem_ack, wait_cnt counts stalled cycles
// ERR   | memory timeout; whole pipeline frozen until reset
module hazard_stall_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    hazard_stall_ctrl_if.slave hz
);
    localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_q, wait_d;
    logic             mem_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_stall;
    logic             lw_stall;
    logic             stall_f_int;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (we_m && rd_m != '0 && rd_m == rs)
            sel = 2'b10;
        else if (we_w && rd_w != '0 && rd_w == rs)
            sel = 2'b01;
        return sel;
    endfunction

    assign hz.forward_a_e = fwd_sel(hz.rs1_e, hz.rd_m, hz.reg_write_m,
                                    hz.rd_w, hz.reg_write_w);
    assign hz.forward_b_e = fwd_sel(hz.rs2_e, hz.rd_m, hz.reg_write_m,
                                    hz.rd_w, hz.reg_write_w);

    assign lw_stall = hz.load_e && (hz.rd_e != '0) &&
                      ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= (state_d == ST_ERR);
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        mem_stall   = 1'b0;
        stall_f_int = 1'b0;
        hz.stall_d  = 1'b0;
        hz.stall_e  = 1'b0;
        hz.stall_m  = 1'b0;
        hz.flush_d  = 1'b0;
        hz.flush_e  = 1'b0;
        hz.flush_w  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mem_stall = hz.dmem_req_m && !hz.dmem_ack;
                if (mem_stall) begin
                    state_d = ST_WAIT;
                    wait_d  = WCW'(1);
                end
            end
            ST_WAIT: begin
                mem_stall = hz.dmem_req_m && !hz.dmem_ack;
                if (mem_stall) begin
                    if (wait_q == WAIT_LAST)
                        state_d = ST_ERR;
                    else
                        wait_d = wait_q + WCW'(1);
                end else begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end
            end
            ST_ERR: begin
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = '0;
            end
        endcase

        // Freezing every stage up to EX-MEM defers any branch or load-use
        // decision: EX is held, so it is re-evaluated once released.
        if (state_q == ST_ERR || mem_stall) begin
            stall_f_int = 1'b1;
            hz.stall_d  = 1'b1;
            hz.stall_e  = 1'b1;
            hz.stall_m  = 1'b1;
            hz.flush_w  = 1'b1;
        end else begin
            stall_f_int = lw_stall;
            hz.stall_d  = lw_stall;
            hz.flush_d  = hz.pc_src_e;
            hz.flush_e  = lw_stall || hz.pc_src_e;
        end
    end

    assign hz.stall_f = stall_f_int;
    assign hz.mem_err = mem_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (stall_f_int && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign hz.stall_cycles = cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
    localparam int REG_AW      = 5;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    typedef struct packed {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic       load_e, pc_src_e;
        logic [4:0] rd_m;
        logic       reg_write_m;
        logic [4:0] rd_w;
        logic       reg_write_w;
        logic       dmem_req_m, dmem_ack;
    } in_t;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic sf, sd, se, sm, fd, fe, fw, err;
    } out_t;

    typedef struct packed {
        logic rst_n;
        in_t  in;
        out_t exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [CNT_W-1:0] exp_cnt;

    vec_t  sb_q[$];
    string name_q[$];

    hazard_stall_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

    hazard_stall_ctrl #(
        .REG_AW(REG_AW),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hz(hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mi(
        input int rs1_d, input int rs2_d, input int rs1_e, input int rs2_e,
        input int rd_e, input bit load_e, input bit pc_src_e,
        input int rd_m, input bit rwm, input int rd_w, input bit rww,
        input bit req, input bit ack
    );
        in_t x;
        x.rs1_d = 5'(rs1_d); x.rs2_d = 5'(rs2_d);
        x.rs1_e = 5'(rs1_e); x.rs2_e = 5'(rs2_e); x.rd_e = 5'(rd_e);
        x.load_e = load_e; x.pc_src_e = pc_src_e;
        x.rd_m = 5'(rd_m); x.reg_write_m = rwm;
        x.rd_w = 5'(rd_w); x.reg_write_w = rww;
        x.dmem_req_m = req; x.dmem_ack = ack;
        return x;
    endfunction

    function automatic out_t mo(
        input int fa, input int fb, input bit sf, input bit sd, input bit se,
        input bit sm, input bit fd, input bit fe, input bit fw, input bit err
    );
        out_t o;
        o.fa = 2'(fa); o.fb = 2'(fb);
        o.sf = sf; o.sd = sd; o.se = se; o.sm = sm;
        o.fd = fd; o.fe = fe; o.fw = fw; o.err = err;
        return o;
    endfunction

    task automatic step(input string nm, input logic r, input in_t i, input out_t e);
        vec_t v;
        rst_n          = r;
        hz.rs1_d       = i.rs1_d;
        hz.rs2_d       = i.rs2_d;
        hz.rs1_e       = i.rs1_e;
        hz.rs2_e       = i.rs2_e;
        hz.rd_e        = i.rd_e;
        hz.load_e      = i.load_e;
        hz.pc_src_e    = i.pc_src_e;
        hz.rd_m        = i.rd_m;
        hz.reg_write_m = i.reg_write_m;
        hz.rd_w        = i.rd_w;
        hz.reg_write_w = i.reg_write_w;
        hz.dmem_req_m  = i.dmem_req_m;
        hz.dmem_ack    = i.dmem_ack;
        v.rst_n = r;
        v.in    = i;
        v.exp   = e;
        sb_q.push_back(v);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare combinational outputs mid-cycle, then advance the
    // stall counter model for the coming edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            vec_t  e;
            string nm;
            out_t  act;
            logic [CNT_W-1:0] cw;
            e  = sb_q.pop_front();
            nm = name_q.pop_front();
            act = {hz.forward_a_e, hz.forward_b_e, hz.stall_f, hz.stall_d,
                   hz.stall_e, hz.stall_m, hz.flush_d, hz.flush_e, hz.flush_w,
                   hz.mem_err};
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s outputs: got %h want %h (fa fb sf sd se sm fd fe fw err)",
                         nm, act, e.exp);
            end
            cw = e.rst_n ? exp_cnt : '0;
            total++;
            if (hz.stall_cycles !== cw) begin
                bad++;
                $display("FAIL %s stall_cycles: got %0d want %0d", nm, hz.stall_cycles, cw);
            end
            if (!e.rst_n)
                exp_cnt = '0;
            else if (e.exp.sf && exp_cnt != '1)
                exp_cnt = exp_cnt + 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t  tbl[15];
    string tname[15];

    initial begin
        out_t NRM, LW, BR, LWBR, MEMO, ERRO;
        in_t  Z;
        total   = 0;
        bad     = 0;
        exp_cnt = '0;
        NRM  = mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        LW   = mo(0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
        BR   = mo(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        LWBR = mo(0, 0, 1, 1, 0, 0, 1, 1, 0, 0);
        MEMO = mo(0, 0, 1, 1, 1, 1, 0, 0, 1, 0);
        ERRO = mo(0, 0, 1, 1, 1, 1, 0, 0, 1, 1);
        Z    = '0;

        tname[0]  = "reset";      tbl[0]  = '{1'b0, Z, NRM};
        tname[1]  = "fwd_a_mem";  tbl[1]  = '{1'b1, mi(0,0,5,0,0,0,0,5,1,5,1,0,0), mo(2,0,0,0,0,0,0,0,0,0)};
        tname[2]  = "fwd_a_wb";   tbl[2]  = '{1'b1, mi(0,0,5,0,0,0,0,0,1,5,1,0,0), mo(1,0,0,0,0,0,0,0,0,0)};
        tname[3]  = "fwd_a_x0";   tbl[3]  = '{1'b1, mi(0,0,0,0,0,0,0,0,1,0,1,0,0), NRM};
        tname[4]  = "fwd_b_mem";  tbl[4]  = '{1'b1, mi(0,0,0,9,0,0,0,9,1,9,1,0,0), mo(0,2,0,0,0,0,0,0,0,0)};
        tname[5]  = "fwd_b_wb";   tbl[5]  = '{1'b1, mi(0,0,0,9,0,0,0,9,0,9,1,0,0), mo(0,1,0,0,0,0,0,0,0,0)};
        tname[6]  = "fwd_split";  tbl[6]  = '{1'b1, mi(0,0,3,4,0,0,0,3,1,4,1,0,0), mo(2,1,0,0,0,0,0,0,0,0)};
        tname[7]  = "lw_rs2";     tbl[7]  = '{1'b1, mi(0,7,0,0,7,1,0,0,0,0,0,0,0), LW};
        tname[8]  = "lw_release"; tbl[8]  = '{1'b1, mi(0,7,0,0,7,0,0,0,0,0,0,0,0), NRM};
        tname[9]  = "lw_rd_x0";   tbl[9]  = '{1'b1, mi(0,0,0,0,0,1,0,0,0,0,0,0,0), NRM};
        tname[10] = "lw_rs1";     tbl[10] = '{1'b1, mi(3,0,0,0,3,1,0,0,0,0,0,0,0), LW};
        tname[11] = "branch";     tbl[11] = '{1'b1, mi(0,0,0,0,0,0,1,0,0,0,0,0,0), BR};
        tname[12] = "branch_lw";  tbl[12] = '{1'b1, mi(3,0,0,0,3,1,1,0,0,0,0,0,0), LWBR};
        tname[13] = "ack_no_req"; tbl[13] = '{1'b1, mi(0,0,0,0,0,0,0,0,0,0,0,0,1), NRM};
        tname[14] = "req_ack";    tbl[14] = '{1'b1, mi(0,0,0,0,0,0,0,0,0,0,0,1,1), NRM};

        rst_n = 1'b0;
        hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_e = '0; hz.rs2_e = '0; hz.rd_e = '0;
        hz.load_e = 1'b0; hz.pc_src_e = 1'b0; hz.rd_m = '0; hz.reg_write_m = 1'b0;
        hz.rd_w = '0; hz.reg_write_w = 1'b0; hz.dmem_req_m = 1'b0; hz.dmem_ack = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 15; k++)
            step(tname[k], tbl[k].rst_n, tbl[k].in, tbl[k].exp);

        // memory wait of 3 cycles with a deferred branch and load-use,
        // released in the ack cycle where the branch is resolved normally
        for (int k = 0; k < 3; k++)
            step($sformatf("memwait_%0d", k), 1'b1, mi(3,0,0,0,3,1,1,0,0,0,0,1,0), MEMO);
        step("memwait_ack", 1'b1, mi(0,0,0,0,0,0,1,0,0,0,0,1,1), BR);

        // request withdrawn while waiting also releases
        step("memdrop_wait", 1'b1, mi(0,0,0,0,0,0,0,0,0,0,0,1,0), MEMO);
        step("memdrop_rel",  1'b1, mi(0,0,0,0,0,0,0,0,0,0,0,0,0), NRM);

        // timeout: MEM_TIMEOUT stalled cycles, then absorbing ERR
        for (int k = 0; k < MEM_TIMEOUT; k++)
            step($sformatf("timeout_wait_%0d", k), 1'b1, mi(0,0,0,0,0,0,0,0,0,0,0,1,0), MEMO);
        step("err_idle",   1'b1, Z, ERRO);
        step("err_ack",    1'b1, mi(0,0,0,0,0,0,0,0,0,0,0,1,1), ERRO);
        step("err_branch", 1'b1, mi(0,0,0,0,0,0,1,0,0,0,0,0,0), ERRO);
        step("err_lw",     1'b1, mi(3,0,0,0,3,1,1,0,0,0,0,0,0), ERRO);
        step("err_hold",   1'b1, Z, ERRO);
        step("err_reset",  1'b0, Z, NRM);
        step("post_reset", 1'b1, mi(0,0,0,0,0,0,0,0,0,0,0,1,1), NRM);

        // reset in the middle of a wait: outputs remain Mealy in IDLE
        step("rstwait_enter", 1'b1, mi(0,0,0,0,0,0,0,0,0,0,0,1,0), MEMO);
        step("rstwait_rst",   1'b0, mi(0,0,0,0,0,0,0,0,0,0,0,1,0), MEMO);
        step("rstwait_rel",   1'b1, Z, NRM);
        for (int k = 0; k < MEM_TIMEOUT - 1; k++)
            step($sformatf("rstwait_full_%0d", k), 1'b1, mi(0,0,0,0,0,0,0,0,0,0,0,1,0), MEMO);
        step("rstwait_noerr", 1'b1, Z, NRM);

        // saturation of the 4-bit stall counter
        step("sat_reset", 1'b0, Z, NRM);
        for (int k = 0; k < 20; k++)
            step($sformatf("sat_lw_%0d", k), 1'b1, mi(0,7,0,0,7,1,0,0,0,0,0,0,0), LW);
        step("sat_end", 1'b1, Z, NRM);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage RV32I core. It drives the en/clear pins of the F/D/E/M/W pipeline registers and the PC register (stall = ~en, flush = clear). It produces EX-stage forwarding selects, detects load-use hazards and branch redirects, and runs a data-memory wait FSM with timeout. It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_AW, 5, register index width
MEM_TIMEOUT, 64, max consecutive memory-wait cycles before error (>=2)
CNT_W, 32, stall performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rs1_d, rs2_d  in  REG_AW  source regs in ID
rs1_e, rs2_e, rd_e  in  REG_AW  source/dest regs in EX
load_e  in  1  EX instruction is a load (result_src from memory)
pc_src_e  in  1  branch/jump taken, resolved in EX
rd_m  in  REG_AW  dest reg in MEM
reg_write_m  in  1  MEM instruction writes the register file
rd_w  in  REG_AW  dest reg in WB
reg_write_w  in  1  WB instruction writes the register file
dmem_req_m  in  1  MEM stage is accessing data memory
dmem_ack  in  1  data memory completes the access this cycle
forward_a_e, forward_b_e  out  2  00 regfile, 01 WB result, 10 MEM ALU result
stall_f, stall_d, stall_e, stall_m  out  1  hold PC / IF-ID / ID-EX / EX-MEM registers
flush_d, flush_e, flush_w  out  1  clear IF-ID / ID-EX / MEM-WB registers
mem_err  out  1  sticky memory timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with stall_f=1

Behaviour:
- Forwarding (combinational):
  - forward_a_e = 10 if reg_write_m & rd_m!=0 & rd_m==rs1_e.
  - Else 01 if reg_write_w & rd_w!=0 & rd_w==rs1_e.
  - Else 00. MEM has priority over WB. forward_b_e is identical using rs2_e.
- Load-use hazard: lw_stall = load_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
- FSM states: IDLE, WAIT, ERR. Reset → IDLE, wait_cnt=0, mem_err=0, stall_cycles=0.
  - mem_stall = dmem_req_m & ~dmem_ack, evaluated in IDLE and WAIT. This is Mealy: stall is asserted in the same cycle the request is not acked.
  - IDLE: if mem_stall → WAIT, wait_cnt=1.
  - WAIT, mem_stall: wait_cnt increments. If wait_cnt==MEM_TIMEOUT-1 while mem_stall → ERR.
  - WAIT, ack (or dmem_req_m drops): → IDLE, wait_cnt=0. That cycle is not stalled.
  - ERR: absorbing until rst_n low. mem_err=1 (registered, asserted the cycle after the transition).
- Output priority (highest first):
  1. ERR: stall_f/d/e/m=1, flush_w=1, flush_d=flush_e=0.
  2. mem_stall: same as ERR. Any pending pc_src_e/lw_stall is deferred, because EX is frozen and re-evaluated after release.
  3. Normal operation:
     - stall_f = stall_d = lw_stall
     - flush_d = pc_src_e
     - flush_e = lw_stall | pc_src_e
     - stall_e = stall_m = flush_w = 0
- Simultaneous lw_stall & pc_src_e: outputs follow the equations above. flush_e=1 and flush_d=1; the register's clear beats its en.
- stall_cycles: +1 on each clk with stall_f=1, saturates at all-ones, no wrap.
- Reset mid-wait: FSM returns to IDLE immediately (async) and the counter clears. Outputs then follow the combinational equations with state IDLE.

Test Plan:
- Forwarding: rd_m=rd_w=rs1_e=5, both reg_write=1 → forward_a_e=10. Set rd_m=0 → 01. Set rs1_e=0 with rd_w=0 → 00.
- Load-use: load_e=1, rd_e=7, rs2_d=7 → stall_f=stall_d=flush_e=1 for exactly 1 cycle. With rd_e=0 → no stall.
- Branch: pc_src_e=1 → flush_d=flush_e=1, stall_f=0. Also check pc_src_e together with lw_stall.
- Memory wait: dmem_req_m=1 with ack after 3 cycles → stall_f/d/e/m=flush_w=1 for 3 cycles, released in the ack cycle. stall_cycles increases by 3.
- Timeout: MEM_TIMEOUT=4, ack never asserted → ERR reached, mem_err=1 and all stalls held indefinitely. Pulse rst_n low → mem_err=0, stall_cycles=0, state IDLE.
- Saturation: CNT_W=4, hold lw_stall for 20 cycles → stall_cycles stops at 15.
